// File: rtl/id_ex_pipe_reg_if.sv
// ID -> ID/EX -> EX signal bundle for id_ex_pipe_reg: ID payload, forwarding sources,
// pipeline control and the registered EX-side outputs.
interface id_ex_pipe_reg_if #(
  parameter int XLEN   = 32,
  parameter int NFWD   = 2,
  parameter int CTRL_W = 10
);
  logic                   flush_i;
  logic                   stall_i;
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [CTRL_W-1:0]      ctrl_i;
  logic [4:0]             rs1_addr_i;
  logic [4:0]             rs2_addr_i;
  logic [XLEN-1:0]        rs1_data_i;
  logic [XLEN-1:0]        rs2_data_i;
  logic [XLEN-1:0]        imm_i;
  logic [XLEN-1:0]        pc_i;
  logic [31:0]            inst_i;
  logic [4:0]             rd_i;
  logic [NFWD-1:0]        fwd_valid_i;
  logic [NFWD*5-1:0]      fwd_rd_i;
  logic [NFWD*XLEN-1:0]   fwd_data_i;
  logic [NFWD-1:0]        fwd_pending_i;
  logic                   out_valid_o;
  logic [CTRL_W-1:0]      ctrl_o;
  logic [XLEN-1:0]        rs1_data_o;
  logic [XLEN-1:0]        rs2_data_o;
  logic [XLEN-1:0]        imm_o;
  logic [XLEN-1:0]        pc_o;
  logic [2:0]             func3_o;
  logic [6:0]             func7_o;
  logic [4:0]             rd_o;
  logic                   hazard_o;

  modport master (
    output flush_i, stall_i, in_valid_i, ctrl_i, rs1_addr_i, rs2_addr_i,
           rs1_data_i, rs2_data_i, imm_i, pc_i, inst_i, rd_i,
           fwd_valid_i, fwd_rd_i, fwd_data_i, fwd_pending_i,
    input  in_ready_o, out_valid_o, ctrl_o, rs1_data_o, rs2_data_o, imm_o, pc_o,
           func3_o, func7_o, rd_o, hazard_o
  );

  modport slave (
    input  flush_i, stall_i, in_valid_i, ctrl_i, rs1_addr_i, rs2_addr_i,
           rs1_data_i, rs2_data_i, imm_i, pc_i, inst_i, rd_i,
           fwd_valid_i, fwd_rd_i, fwd_data_i, fwd_pending_i,
    output in_ready_o, out_valid_o, ctrl_o, rs1_data_o, rs2_data_o, imm_o, pc_o,
           func3_o, func7_o, rd_o, hazard_o
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with N-source priority forwarding, load-use bubbles, stall and flush.
// Define ID_EX_HAZARD_CNT_EN to add saturating hazard/flush counters.
module id_ex_pipe_reg #(
  parameter int XLEN   = 32,
  parameter int NFWD   = 2,
  parameter int CTRL_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  id_ex_pipe_reg_if.slave bus
`ifdef ID_EX_HAZARD_CNT_EN
  ,
  output logic [CNT_W-1:0] hazard_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [4:0]        rd;
  } ex_t;

  ex_t             ex_q;
  ex_t             ex_d;
  logic [XLEN-1:0] rs1_sel;
  logic [XLEN-1:0] rs2_sel;
  logic            rs1_hit;
  logic            rs2_hit;
  logic            hazard;
  logic            unused_inst_bits;

  // The lowest-index matching source wins; a pending winner is a load-use hit,
  // never a fall-through to a lower-priority source.
  function automatic void fwd_select(
    input  logic [4:0]           addr,
    input  logic [XLEN-1:0]      rf_data,
    input  logic [NFWD-1:0]      valid,
    input  logic [NFWD*5-1:0]    rd,
    input  logic [NFWD*XLEN-1:0] data,
    input  logic [NFWD-1:0]      pending,
    output logic [XLEN-1:0]      sel,
    output logic                 hit
  );
    logic found;
    sel   = rf_data;
    hit   = 1'b0;
    found = 1'b0;
    for (int k = 0; k < NFWD; k++) begin
      if (!found && valid[k] && (rd[k*5 +: 5] == addr) && (addr != 5'd0)) begin
        found = 1'b1;
        if (pending[k]) hit = 1'b1;
        else            sel = data[k*XLEN +: XLEN];
      end
    end
  endfunction

  always_comb begin
    rs1_sel = '0;
    rs2_sel = '0;
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    fwd_select(bus.rs1_addr_i, bus.rs1_data_i, bus.fwd_valid_i, bus.fwd_rd_i,
               bus.fwd_data_i, bus.fwd_pending_i, rs1_sel, rs1_hit);
    fwd_select(bus.rs2_addr_i, bus.rs2_data_i, bus.fwd_valid_i, bus.fwd_rd_i,
               bus.fwd_data_i, bus.fwd_pending_i, rs2_sel, rs2_hit);
  end

  assign hazard         = bus.in_valid_i & (rs1_hit | rs2_hit) & ~bus.stall_i & ~bus.flush_i;
  assign bus.hazard_o   = hazard;
  assign bus.in_ready_o = rst & ~bus.stall_i & ~hazard;

  // Anything that is not a real capture clears the whole bundle, so ctrl is zero whenever valid is.
  always_comb begin
    ex_d = ex_q;
    if (bus.flush_i) begin
      ex_d = '0;
    end else if (bus.stall_i) begin
      ex_d = ex_q;
    end else if (hazard || !bus.in_valid_i) begin
      ex_d = '0;
    end else begin
      ex_d.valid = 1'b1;
      ex_d.ctrl  = bus.ctrl_i;
      ex_d.rs1   = rs1_sel;
      ex_d.rs2   = rs2_sel;
      ex_d.imm   = bus.imm_i;
      ex_d.pc    = bus.pc_i;
      ex_d.func3 = bus.inst_i[14:12];
      ex_d.func7 = bus.inst_i[31:25];
      ex_d.rd    = bus.rd_i;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) ex_q <= '0;
    else      ex_q <= ex_d;
  end

  assign bus.out_valid_o = ex_q.valid;
  assign bus.ctrl_o      = ex_q.ctrl;
  assign bus.rs1_data_o  = ex_q.rs1;
  assign bus.rs2_data_o  = ex_q.rs2;
  assign bus.imm_o       = ex_q.imm;
  assign bus.pc_o        = ex_q.pc;
  assign bus.func3_o     = ex_q.func3;
  assign bus.func7_o     = ex_q.func7;
  assign bus.rd_o        = ex_q.rd;

  assign unused_inst_bits = ^{bus.inst_i[24:15], bus.inst_i[11:0]};

`ifdef ID_EX_HAZARD_CNT_EN
  logic [CNT_W-1:0] hazard_cnt;
  logic [CNT_W-1:0] flush_cnt;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      hazard_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (hazard && (hazard_cnt != '1))      hazard_cnt <= hazard_cnt + CNT_W'(1);
      if (bus.flush_i && (flush_cnt != '1))  flush_cnt  <= flush_cnt + CNT_W'(1);
    end
  end

  assign hazard_cnt_o = hazard_cnt;
  assign flush_cnt_o  = flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: a per-cycle scoreboard against a behavioural
// model plus directed vectors with literal expectations (counters when ID_EX_HAZARD_CNT_EN is set).
module tb_id_ex_pipe_reg;
  localparam int XLEN   = 32;
  localparam int NFWD   = 2;
  localparam int CTRL_W = 10;
  localparam int CNT_W  = 2;

  logic clk = 1'b1;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic            fv    [NFWD];
  logic [4:0]      frd   [NFWD];
  logic [XLEN-1:0] fdat  [NFWD];
  logic            fpend [NFWD];

  id_ex_pipe_reg_if #(.XLEN(XLEN), .NFWD(NFWD), .CTRL_W(CTRL_W)) bus ();

`ifdef ID_EX_HAZARD_CNT_EN
  logic [CNT_W-1:0] hazard_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  id_ex_pipe_reg #(.XLEN(XLEN), .NFWD(NFWD), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ID_EX_HAZARD_CNT_EN
    ,
    .hazard_cnt_o(hazard_cnt),
    .flush_cnt_o(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign bus.fwd_valid_i   = {fv[1], fv[0]};
  assign bus.fwd_rd_i      = {frd[1], frd[0]};
  assign bus.fwd_data_i    = {fdat[1], fdat[0]};
  assign bus.fwd_pending_i = {fpend[1], fpend[0]};

  // Expected EX-side state, rebuilt from the operation rules on each falling edge.
  logic            m_valid = 1'b0;
  logic [9:0]      m_ctrl  = '0;
  logic [XLEN-1:0] m_rs1   = '0;
  logic [XLEN-1:0] m_rs2   = '0;
  logic [XLEN-1:0] m_imm   = '0;
  logic [XLEN-1:0] m_pc    = '0;
  logic [2:0]      m_f3    = '0;
  logic [6:0]      m_f7    = '0;
  logic [4:0]      m_rd    = '0;
  int              m_hcnt  = 0;
  int              m_fcnt  = 0;

  function automatic int winner(input logic [4:0] addr);
    if (addr == 5'd0) return -1;
    for (int k = 0; k < NFWD; k++)
      if (fv[k] && frd[k] == addr) return k;
    return -1;
  endfunction

  function automatic logic [XLEN-1:0] operand(input logic [4:0] addr, input logic [XLEN-1:0] rf);
    int w;
    w = winner(addr);
    return (w < 0) ? rf : fdat[w];
  endfunction

  function automatic logic model_hazard();
    int  w1;
    int  w2;
    logic hit;
    w1  = winner(bus.rs1_addr_i);
    w2  = winner(bus.rs2_addr_i);
    hit = ((w1 >= 0) && fpend[w1]) || ((w2 >= 0) && fpend[w2]);
    return bus.in_valid_i && hit && !bus.stall_i && !bus.flush_i;
  endfunction

  task automatic model_clear();
    m_valid = 1'b0; m_ctrl = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0;
    m_pc = '0; m_f3 = '0; m_f7 = '0; m_rd = '0;
  endtask

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      model_clear();
      m_hcnt = 0;
      m_fcnt = 0;
    end else begin
      logic hz;
      hz = model_hazard();
      if (hz && m_hcnt < (1 << CNT_W) - 1) m_hcnt++;
      if (bus.flush_i && m_fcnt < (1 << CNT_W) - 1) m_fcnt++;
      if (bus.flush_i) model_clear();
      else if (bus.stall_i) begin end
      else if (hz || !bus.in_valid_i) model_clear();
      else begin
        m_valid = 1'b1;
        m_ctrl  = bus.ctrl_i;
        m_rs1   = operand(bus.rs1_addr_i, bus.rs1_data_i);
        m_rs2   = operand(bus.rs2_addr_i, bus.rs2_data_i);
        m_imm   = bus.imm_i;
        m_pc    = bus.pc_i;
        m_f3    = bus.inst_i[14:12];
        m_f7    = bus.inst_i[31:25];
        m_rd    = bus.rd_i;
      end
    end
  end

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compare(name, act, exp);
  endtask

  // Scoreboard: rising edge is half a cycle away from every state update.
  always @(posedge clk) begin
    logic hz;
    hz = model_hazard();
    compare("sb_valid", bus.out_valid_o, m_valid);
    compare("sb_ctrl",  bus.ctrl_o,      m_ctrl);
    compare("sb_rs1",   bus.rs1_data_o,  m_rs1);
    compare("sb_rs2",   bus.rs2_data_o,  m_rs2);
    compare("sb_imm",   bus.imm_o,       m_imm);
    compare("sb_pc",    bus.pc_o,        m_pc);
    compare("sb_func3", bus.func3_o,     m_f3);
    compare("sb_func7", bus.func7_o,     m_f7);
    compare("sb_rd",    bus.rd_o,        m_rd);
    compare("sb_hazard", bus.hazard_o,   hz);
    compare("sb_ready", bus.in_ready_o,  rst && !bus.stall_i && !hz);
`ifdef ID_EX_HAZARD_CNT_EN
    compare("sb_hcnt", hazard_cnt, m_hcnt);
    compare("sb_fcnt", flush_cnt,  m_fcnt);
`endif
  end

  task automatic setFwd(input int k, input logic v, input logic [4:0] rd,
                        input logic [XLEN-1:0] data, input logic pend);
    fv[k] = v; frd[k] = rd; fdat[k] = data; fpend[k] = pend;
  endtask

  task automatic clearInputs();
    bus.flush_i = 1'b0; bus.stall_i = 1'b0; bus.in_valid_i = 1'b0;
    bus.ctrl_i = '0; bus.rs1_addr_i = '0; bus.rs2_addr_i = '0;
    bus.rs1_data_i = '0; bus.rs2_data_i = '0; bus.imm_i = '0; bus.pc_i = '0;
    bus.inst_i = '0; bus.rd_i = '0;
    for (int k = 0; k < NFWD; k++) setFwd(k, 1'b0, 5'd0, '0, 1'b0);
  endtask

  task automatic applyStimulus(input logic [9:0] ctrl, input logic [4:0] a1, input logic [31:0] d1,
                               input logic [4:0] a2, input logic [31:0] d2,
                               input logic [4:0] rd, input logic [31:0] inst);
    bus.in_valid_i = 1'b1;
    bus.ctrl_i = ctrl;
    bus.rs1_addr_i = a1; bus.rs1_data_i = d1;
    bus.rs2_addr_i = a2; bus.rs2_data_i = d2;
    bus.rd_i = rd; bus.inst_i = inst;
    bus.imm_i = 32'h800 + {27'd0, rd};
    bus.pc_i  = 32'h4000 + {25'd0, rd, 2'b00};
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitEdge();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearInputs();
    #2 rst = 1'b0;
    nextCycle();
    waitEdge();
    checkOutput("reset_valid", bus.out_valid_o, 0);
    checkOutput("reset_ready", bus.in_ready_o, 0);
    nextCycle();
    rst = 1'b1;
    waitEdge();

    // plain capture
    nextCycle();
    applyStimulus(10'h155, 5'd1, 32'd5, 5'd2, 32'd9, 5'd10, 32'h4000_5033);
    #1 checkOutput("plain_ready", bus.in_ready_o, 1);
    waitEdge();
    checkOutput("plain_valid", bus.out_valid_o, 1);
    checkOutput("plain_ctrl",  bus.ctrl_o, 10'h155);
    checkOutput("plain_rs1",   bus.rs1_data_o, 5);
    checkOutput("plain_func3", bus.func3_o, 5);
    checkOutput("plain_func7", bus.func7_o, 7'h20);
    checkOutput("plain_rd",    bus.rd_o, 10);

    // priority forwarding and x0
    nextCycle();
    applyStimulus(10'h0A3, 5'd3, 32'h11, 5'd2, 32'h22, 5'd4, 32'h0000_2013);
    setFwd(0, 1'b1, 5'd3, 32'hAA, 1'b0);
    setFwd(1, 1'b1, 5'd3, 32'hBB, 1'b0);
    waitEdge();
    checkOutput("prio_rs1", bus.rs1_data_o, 32'hAA);
    checkOutput("prio_rs2", bus.rs2_data_o, 32'h22);
    nextCycle();
    applyStimulus(10'h0A3, 5'd5, 32'h55, 5'd0, 32'h77, 5'd6, 32'h0000_2013);
    setFwd(0, 1'b1, 5'd0, 32'hCC, 1'b0);
    setFwd(1, 1'b0, 5'd0, 32'h0, 1'b0);
    waitEdge();
    checkOutput("x0_rs2", bus.rs2_data_o, 32'h77);
    checkOutput("x0_rs1", bus.rs1_data_o, 32'h55);

    // pending src0 shadows a ready src1 on the same register
    nextCycle();
    applyStimulus(10'h0A3, 5'd4, 32'h40, 5'd2, 32'h22, 5'd6, 32'h0000_2013);
    setFwd(0, 1'b1, 5'd4, 32'h44, 1'b1);
    setFwd(1, 1'b1, 5'd4, 32'h99, 1'b0);
    #1 checkOutput("shadow_hazard", bus.hazard_o, 1);
    waitEdge();
    checkOutput("shadow_valid", bus.out_valid_o, 0);
    checkOutput("shadow_ctrl",  bus.ctrl_o, 0);

    // load-use bubble, then forwarded capture
    nextCycle();
    applyStimulus(10'h3FF, 5'd1, 32'h1, 5'd7, 32'h7, 5'd8, 32'hFE00_7033);
    setFwd(0, 1'b1, 5'd7, 32'h0, 1'b1);
    setFwd(1, 1'b0, 5'd0, 32'h0, 1'b0);
    #1 checkOutput("lu_hazard", bus.hazard_o, 1);
    checkOutput("lu_ready", bus.in_ready_o, 0);
    waitEdge();
    checkOutput("lu_bubble_ctrl",  bus.ctrl_o, 0);
    checkOutput("lu_bubble_valid", bus.out_valid_o, 0);
    nextCycle();
    setFwd(0, 1'b1, 5'd7, 32'h1234, 1'b0);
    #1 checkOutput("lu_hazard_clear", bus.hazard_o, 0);
    waitEdge();
    checkOutput("lu_rs2",   bus.rs2_data_o, 32'h1234);
    checkOutput("lu_valid", bus.out_valid_o, 1);
    checkOutput("lu_func7", bus.func7_o, 7'h7F);
    checkOutput("lu_func3", bus.func3_o, 3'd7);

    // stall beats a pending hit, then flush beats stall
    nextCycle();
    applyStimulus(10'h001, 5'd7, 32'hDEAD, 5'd7, 32'hBEEF, 5'd9, 32'h0000_0033);
    setFwd(0, 1'b1, 5'd7, 32'h0, 1'b1);
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) nextCycle();
      #1 checkOutput("stall_hazard", bus.hazard_o, 0);
      waitEdge();
      checkOutput("stall_rs2",  bus.rs2_data_o, 32'h1234);
      checkOutput("stall_ctrl", bus.ctrl_o, 10'h3FF);
    end
    nextCycle();
    bus.flush_i = 1'b1;
    waitEdge();
    checkOutput("sflush_valid", bus.out_valid_o, 0);
    checkOutput("sflush_rs2",   bus.rs2_data_o, 0);

    // asynchronous reset mid-stall
    nextCycle();
    clearInputs();
    applyStimulus(10'h155, 5'd1, 32'hCAFE, 5'd2, 32'hBEEF, 5'd9, 32'h4000_5033);
    waitEdge();
    checkOutput("ar_pre_valid", bus.out_valid_o, 1);
    nextCycle();
    bus.stall_i = 1'b1;
    #2 rst = 1'b0;
    #1 checkOutput("ar_valid", bus.out_valid_o, 0);
    checkOutput("ar_ctrl", bus.ctrl_o, 0);
    checkOutput("ar_rs1",  bus.rs1_data_o, 0);
    nextCycle();
    rst = 1'b1;
    clearInputs();
    waitEdge();

    // five hazard bubbles, then one flush
    nextCycle();
    applyStimulus(10'h0F0, 5'd1, 32'h1, 5'd7, 32'h7, 5'd3, 32'h0000_0033);
    setFwd(0, 1'b1, 5'd7, 32'h0, 1'b1);
    repeat (5) begin
      waitEdge();
      nextCycle();
    end
    bus.flush_i = 1'b1;
    #1 checkOutput("fl_ready", bus.in_ready_o, 1);
    checkOutput("fl_hazard", bus.hazard_o, 0);
    waitEdge();
    checkOutput("fl_valid", bus.out_valid_o, 0);
`ifdef ID_EX_HAZARD_CNT_EN
    checkOutput("cnt_hazard_sat", hazard_cnt, 3);
    checkOutput("cnt_flush", flush_cnt, 1);
`endif
    nextCycle();
    clearInputs();
    waitEdge();
    nextCycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised ID/EX pipeline register for the RISC-V core; successor to the fixed two-source ID/EX buffer. Captures decoded control, operands, immediate and PC from ID on the falling edge of `clk` and presents them to EX. Adds the following over the fixed buffer:
- N-source priority forwarding with internal address compare.
- Load-use hazard detection with bubble insertion.
- Downstream stall (hold).
- Valid/ready handshake toward ID.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `NFWD`, 2, number of forwarding sources; index 0 has highest priority (youngest stage).
- `CTRL_W`, 10, packed control width {MemRead, MemtoReg, MemWrite, RegWrite, ALUSrc[1:0], ALUOp[3:0]}.
- `CNT_W`, 16, hazard counter width.

Ports:
- `clk` in 1: the only clock. All state updates on its falling edge.
- `rst` in 1: asynchronous, active-low reset.
- `flush_i` in 1: squash ID/EX contents (branch/jump redirect).
- `stall_i` in 1: EX cannot accept; hold all outputs.
- `in_valid_i` in 1: ID presents a valid instruction.
- `in_ready_o` out 1: block accepts the ID instruction at this edge.
- `ctrl_i` in CTRL_W: packed control.
- `rs1_addr_i`, `rs2_addr_i` in 5: source register numbers.
- `rs1_data_i`, `rs2_data_i` in XLEN: register-file read data.
- `imm_i`, `pc_i` in XLEN; `inst_i` in 32; `rd_i` in 5.
- `fwd_valid_i` in NFWD: source k writes a register.
- `fwd_rd_i` in NFWD*5: destination register of source k (slice k).
- `fwd_data_i` in NFWD*XLEN: result of source k.
- `fwd_pending_i` in NFWD: source k data not yet available (load in EX).
- `out_valid_o` out 1; `ctrl_o` out CTRL_W; `rs1_data_o`, `rs2_data_o`, `imm_o`, `pc_o` out XLEN.
- `func3_o` out 3; `func7_o` out 7; `rd_o` out 5.
- `hazard_o` out 1: load-use bubble inserted at the coming edge (combinational).
- `hazard_cnt_o`, `flush_cnt_o` out CNT_W: present only with the configuration macro.

## Operation
**Forwarding**, per operand j ∈ {1,2}:
- Scan k = 0..NFWD-1. First k with `fwd_valid_i[k]`, `fwd_rd_i[k]==rsj_addr_i` and `rsj_addr_i!=0` wins.
- If no source wins: captured data = `rsj_data_i`.
- If a source wins and `fwd_pending_i[k]`=0: captured data = `fwd_data_i[k]`.
- If a source wins and `fwd_pending_i[k]`=1: load-use hit on operand j.
- x0 is never forwarded. Lower-priority matches are ignored once a higher-priority source wins.

**Hazard:** `hazard_o` = `in_valid_i` & (hit on rs1 | hit on rs2) & `!stall_i` & `!flush_i`.

**Ready:** `in_ready_o` = `rst` & `!stall_i` & `!hazard_o`. When `flush_i`=1 and `stall_i`=0, `in_ready_o`=1 and the input is discarded.

**Update priority at each falling edge:**
1. `rst` low: all outputs 0, asynchronously.
2. `flush_i`: all outputs 0, including `out_valid_o`.
3. `stall_i`: all outputs hold.
4. `hazard_o`: bubble. `out_valid_o`=0, `ctrl_o`=0, `rd_o`=0; data outputs don't-care (driven 0).
5. `in_valid_i`: capture. `out_valid_o`=1; `func3_o`=`inst_i[14:12]`; `func7_o`=`inst_i[31:25]`; operands per forwarding.
6. Otherwise: bubble as in step 4.

**Bubble invariant:** `ctrl_o` is 0 whenever `out_valid_o`=0. EX is never required to check valid.

## Timing
- Latency: one falling edge from ID input to EX output. Forward compare and mux are combinational ahead of the capture edge.
- Reset values: every output 0; counters 0. Reset deassertion takes effect at the next falling edge.
- Load-use: exactly one bubble per hazard. The source advances and drops `fwd_pending_i`, so the next edge captures the forwarded data. ID must hold its inputs while `in_ready_o`=0.
- `flush_i` together with `stall_i`: flush wins.
- `stall_i` together with a pending hit: stall wins; `hazard_o`=0 and no bubble.
- Reset asserted mid-stall or mid-hazard: immediate clear; no residual hold.
- A single operand matched by several sources: the lowest index wins, even if a higher index is non-pending.

## Configuration
- `ID_EX_HAZARD_CNT_EN` defined:
  - `hazard_cnt_o` increments on each edge where `hazard_o`=1.
  - `flush_cnt_o` increments on each edge where `flush_i`=1.
  - Both saturate at 2^CNT_W-1 and reset to 0.
- Not defined: both ports and both counters are absent.

## Test plan
- **Plain capture:** `in_valid_i`=1, `ctrl_i`=10'h155, `rs1_data_i`=5, no fwd match -> after the falling edge, `out_valid_o`=1, `ctrl_o`=10'h155, `rs1_data_o`=5.
- **Priority forward:** rs1=x3; src0 rd=3 data=0xAA; src1 rd=3 data=0xBB; both valid -> `rs1_data_o`=0xAA. rs2=x0 with src0 rd=0 -> register-file value kept.
- **Load-use:** src0 rd=7 pending=1, rs2=x7 -> `hazard_o`=1, `in_ready_o`=0, bubble out (`ctrl_o`=0). Next edge pending=0, data=0x1234 -> `rs2_data_o`=0x1234, `out_valid_o`=1.
- **Stall vs hazard:** `stall_i`=1 with a pending hit for 3 edges -> outputs unchanged, `hazard_o`=0. Then `stall_i`=1 with `flush_i`=1 -> outputs 0.
- **Async reset:** `rst` low mid-cycle while `out_valid_o`=1 -> all outputs 0 without any clock edge.
- **Counters (macro on, CNT_W=2):** 5 hazard bubbles -> `hazard_cnt_o` saturates at 3. 1 flush -> `flush_cnt_o`=1.
